tinytone_poly: RTL and testbench
================================

# tinytone_poly

Parametrised polyphonic square-wave tone core, successor to the single-tone TinyTone design. It holds CHANNELS independent programmable dividers, each with its own period and volume register, mixes the enabled channels and emits a 1-bit PWM audio stream. It sits under the `tt_um_` wrapper: the wrapper decodes `ui_in`/`uio_in` into the write port below and drives `pwm_out` and `tone_out` onto `uo_out`.

## Interface
- `CHANNELS`, default 4: number of tone channels, ≥1.
- `DIV_W`, default 12: period register and divider counter width.
- `VOL_W`, default 4: per-channel volume width.
- `ADDR_W`, default `max(1,$clog2(CHANNELS))`: channel address width (derived).
- `MIX_W`, default `VOL_W+$clog2(CHANNELS+1)`: mix sum and PWM counter width (derived).

Ports:
- `clk` in 1: system clock; all state on rising edge.
- `rst_n` in 1: reset, asynchronous and active-low; one clock domain.
- `ena` in 1: design enable; low freezes tone and PWM state.
- `wr_en` in 1: register write strobe, one write per cycle.
- `wr_sel` in 1: 0 = period register, 1 = volume register.
- `wr_addr` in ADDR_W: target channel.
- `wr_data` in DIV_W: write data; volume writes use `[VOL_W-1:0]`.
- `tone_out` out CHANNELS: raw square wave per channel.
- `pwm_out` out 1: mixed PWM audio.

## Operation
- Per channel i: `period[i]` (DIV_W), `vol[i]` (VOL_W), `cnt[i]` (DIV_W), `sq[i]` (1). `tone_out[i] = sq[i]`.
- Writes are accepted regardless of `ena`. `wr_addr ≥ CHANNELS` is ignored (no state change).
- Period write to channel i: `period[i]` and `cnt[i]` both load `wr_data`; `sq[i]` unchanged. This takes priority over reload/toggle in the same cycle, so no toggle occurs that cycle.
- Volume write: `vol[i]` loads; no effect on divider state.
- Divider, when `ena=1` and `period[i]≠0`: if `cnt[i]≠0` decrement, else reload `cnt[i]=period[i]` and toggle `sq[i]`. Half-period = period+1 cycles; f = f_clk/(2·(period+1)).
- `period[i]=0`: channel muted; `sq[i]` and `cnt[i]` are forced to 0 on the next edge.
- Mix: `mix_c = Σ (sq[i] ? vol[i] : 0)`, unsigned and zero-extended to MIX_W; it cannot overflow by construction.
- PWM: `pwm_cnt` (MIX_W) increments when `ena=1` and wraps from 2^MIX_W−1 to 0. On the edge where `pwm_cnt = 2^MIX_W−1` (and `ena=1`), `mix_q <= mix_c`. Duty is therefore updated only at frame boundaries.
- `pwm_out = ena & (mix_q > pwm_cnt)`, a compare of flops only. Duty = mix_q / 2^MIX_W.
- `ena=0`: `cnt`, `sq`, `pwm_cnt` and `mix_q` hold; `pwm_out` is 0; `tone_out` holds its last value.

## Timing
- Reset (async assert, sync release by the wrapper's reset tree): all `period`, `vol`, `cnt`, `sq`, `mix_q` and `pwm_cnt` are 0. Hence `tone_out=0` and `pwm_out=0`.
- Reset asserted mid-operation clears everything within the same cycle, with no clock needed.
- Period write P at edge k: `cnt=P` after edge k. `sq` toggles at edges k+P+1, k+2(P+1), and so on.
- P=1 gives a toggle every 2 cycles. Maximum P = 2^DIV_W−1.
- Mix latency: an `sq`/`vol` change reaches `pwm_out` at the next frame boundary, which is at most 2^MIX_W cycles away. The new duty applies to the full following frame.
- Simultaneous period write and counter expiry on the same channel: the write wins and there is no toggle.
- Writes to different channels in consecutive cycles are all honoured.

## Test plan
- Reset: hold `rst_n=0` with random writes applied → `tone_out=0`, `pwm_out=0`. Release, `ena=1`, no writes → outputs stay 0 for 1000 cycles.
- Single tone: write ch0 period=3 at edge k → `tone_out[0]` toggles at k+4, k+8, k+12. Other channels stay 0.
- Retune and mute: after running ch1 at period=10, write period=2 at the cycle its cnt reaches 0 → no toggle that cycle, next toggle 3 cycles later. Then write period=0 → `tone_out[1]` is 0 on the next edge and stays 0.
- Mix/PWM (defaults, MIX_W=7): ch0 and ch1 period=1000, vol=5 and 9, both sq high → the frame after the next boundary has `pwm_out` high for exactly 14 of 128 cycles. All four channels at vol=15 and high → 60/128.
- Enable freeze: drop `ena` for 37 cycles mid-tone → `pwm_out=0` and `tone_out`/counter phase are held. Re-raising `ena` resumes the toggle schedule shifted by exactly 37 cycles.
- Address/async reset: a write to `wr_addr=CHANNELS` (e.g. with CHANNELS=3) changes nothing. Pulse `rst_n` low between clock edges mid-tone → all outputs are 0 immediately.

Source files
------------

// File: rtl/tinytone_poly.sv
// tinytone_poly: polyphonic square-wave tone core with a 1-bit PWM mixer.
//
// Each of CHANNELS channels owns a period register, a volume register and a
// down-counting divider whose expiry toggles the channel's square wave. The
// enabled square waves are weighted by volume, summed, and the sum is latched
// once per PWM frame to set the duty of a single-bit PWM output.
//
// Ports:
//   clk       system clock, all state on the rising edge
//   rst_n     asynchronous active-low reset
//   ena       design enable; low freezes divider and PWM state, forces pwm_out low
//   wr_en     register write strobe
//   wr_sel    0 = period register, 1 = volume register
//   wr_addr   target channel; addresses >= CHANNELS are ignored
//   wr_data   write data; volume writes use the low VOL_W bits
//   tone_out  raw square wave per channel
//   pwm_out   mixed PWM audio
module tinytone_poly #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned DIV_W    = 12,
    parameter int unsigned VOL_W    = 4,
    parameter int unsigned ADDR_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    parameter int unsigned MIX_W    = VOL_W + $clog2(CHANNELS + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                wr_en,
    input  logic                wr_sel,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DIV_W-1:0]    wr_data,
    output logic [CHANNELS-1:0] tone_out,
    output logic                pwm_out
);

    logic [DIV_W-1:0]    period_q [CHANNELS];
    logic [DIV_W-1:0]    period_d [CHANNELS];
    logic [DIV_W-1:0]    cnt_q    [CHANNELS];
    logic [DIV_W-1:0]    cnt_d    [CHANNELS];
    logic [VOL_W-1:0]    vol_q    [CHANNELS];
    logic [VOL_W-1:0]    vol_d    [CHANNELS];
    logic [CHANNELS-1:0] sq_q;
    logic [CHANNELS-1:0] sq_d;
    logic [CHANNELS-1:0] wr_hit_c;

    logic [MIX_W-1:0]    mix_c;
    logic [MIX_W-1:0]    mix_q;
    logic [MIX_W-1:0]    mix_d;
    logic [MIX_W-1:0]    pwm_cnt_q;
    logic [MIX_W-1:0]    pwm_cnt_d;

    // Address decode; out-of-range addresses match no channel.
    always_comb begin
        wr_hit_c = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            wr_hit_c[i] = wr_en && (wr_addr == ADDR_W'(i));
        end
    end

    // Per-channel register writes and divider stepping.
    always_comb begin
        period_d = period_q;
        cnt_d    = cnt_q;
        vol_d    = vol_q;
        sq_d     = sq_q;
        for (int i = 0; i < CHANNELS; i++) begin
            if (wr_hit_c[i] && !wr_sel) begin
                // A period write restarts the divider and suppresses any
                // toggle that would have happened on this edge.
                period_d[i] = wr_data;
                cnt_d[i]    = wr_data;
            end else if (ena) begin
                if (period_q[i] == '0) begin
                    cnt_d[i] = '0;
                    sq_d[i]  = 1'b0;
                end else if (cnt_q[i] != '0) begin
                    cnt_d[i] = cnt_q[i] - DIV_W'(1);
                end else begin
                    cnt_d[i] = period_q[i];
                    sq_d[i]  = ~sq_q[i];
                end
            end
            if (wr_hit_c[i] && wr_sel) begin
                vol_d[i] = wr_data[VOL_W-1:0];
            end
        end
    end

    // Volume-weighted sum of the channels currently high.
    always_comb begin
        mix_c = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (sq_q[i]) begin
                mix_c = mix_c + MIX_W'(vol_q[i]);
            end
        end
    end

    // PWM frame counter; the duty is latched only on the last cycle of a frame.
    always_comb begin
        pwm_cnt_d = pwm_cnt_q;
        mix_d     = mix_q;
        if (ena) begin
            pwm_cnt_d = pwm_cnt_q + MIX_W'(1);
            if (pwm_cnt_q == '1) begin
                mix_d = mix_c;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                period_q[i] <= '0;
                cnt_q[i]    <= '0;
                vol_q[i]    <= '0;
            end
            sq_q      <= '0;
            mix_q     <= '0;
            pwm_cnt_q <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                period_q[i] <= period_d[i];
                cnt_q[i]    <= cnt_d[i];
                vol_q[i]    <= vol_d[i];
            end
            sq_q      <= sq_d;
            mix_q     <= mix_d;
            pwm_cnt_q <= pwm_cnt_d;
        end
    end

    assign tone_out = sq_q;
    // Flop-to-flop compare, gated so a frozen design stays silent.
    assign pwm_out  = ena & (mix_q > pwm_cnt_q);

endmodule

// File: tb/tb_tinytone_poly.sv
// tb_tinytone_poly: bench for tinytone_poly with a behavioural model.
// The model tracks, per channel, the enabled cycles elapsed since the last
// load/toggle, and a global enabled-cycle count whose residue mod the frame
// length gives the PWM phase.
module tb_tinytone_poly;

    localparam int unsigned FRAME = 128;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic        wr_en;
    logic        wr_sel;
    logic [1:0]  wr_addr;
    logic [11:0] wr_data;
    logic [3:0]  tone_out;
    logic        pwm_out;
    logic [2:0]  tone3;
    logic        pwm3;

    int unsigned n_vec;
    int unsigned n_err;

    // Reference model state.
    int unsigned m_per [4];
    int unsigned m_vol [4];
    int unsigned m_el  [4];
    int unsigned m_n;
    int unsigned m_duty;
    bit [3:0]    m_sq;

    tinytone_poly u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .wr_en    (wr_en),
        .wr_sel   (wr_sel),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .tone_out (tone_out),
        .pwm_out  (pwm_out)
    );

    // Three-channel instance for the out-of-range address case.
    tinytone_poly #(.CHANNELS(3)) u_dut3 (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .wr_en    (wr_en),
        .wr_sel   (wr_sel),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .tone_out (tone3),
        .pwm_out  (pwm3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_per[i] = 0;
            m_vol[i] = 0;
            m_el[i]  = 0;
        end
        m_sq   = '0;
        m_n    = 0;
        m_duty = 0;
    endtask

    task automatic model_edge();
        int unsigned mix;
        if (!rst_n) begin
            model_reset();
            return;
        end
        mix = 0;
        for (int i = 0; i < 4; i++) if (m_sq[i]) mix += m_vol[i];
        if (ena) begin
            if (m_n % FRAME == FRAME - 1) m_duty = mix;
            m_n++;
        end
        for (int i = 0; i < 4; i++) begin
            if (wr_en && wr_addr == i && !wr_sel) begin
                m_per[i] = wr_data;
                m_el[i]  = 0;
            end else if (ena) begin
                if (m_per[i] == 0) begin
                    m_sq[i] = 1'b0;
                    m_el[i] = 0;
                end else begin
                    m_el[i]++;
                    if (m_el[i] == m_per[i] + 1) begin
                        m_sq[i] = ~m_sq[i];
                        m_el[i] = 0;
                    end
                end
            end
            if (wr_en && wr_addr == i && wr_sel) m_vol[i] = wr_data % 16;
        end
    endtask

    // One clock: model advances with the edge, outputs sampled 1 time unit later.
    task automatic step();
        logic exp_pwm;
        @(posedge clk);
        model_edge();
        #1;
        exp_pwm = ena && (m_duty > (m_n % FRAME));
        check("tone", 32'(tone_out), 32'(m_sq));
        check("pwm", 32'(pwm_out), 32'(exp_pwm));
    endtask

    task automatic wr(input logic sel, input logic [1:0] addr, input logic [11:0] data);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = addr;
        wr_data = data;
        step();
        wr_en   = 1'b0;
    endtask

    // Reset pulse between clock edges; outputs must clear with no clock.
    task automatic async_reset();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("arst_tone", 32'(tone_out), 32'd0);
        check("arst_pwm", 32'(pwm_out), 32'd0);
        check("arst_tone3", 32'(tone3), 32'd0);
        #1 rst_n = 1'b1;
    endtask

    // Count pwm_out high samples over one full frame starting after a boundary.
    task automatic measure_frame(output int unsigned hi);
        do step(); while (m_n % FRAME != 0);
        hi = 32'(pwm_out);
        repeat (FRAME - 1) begin
            step();
            hi += 32'(pwm_out);
        end
    endtask

    initial begin
        int unsigned hi;
        n_vec   = 0;
        n_err   = 0;
        rst_n   = 1'b0;
        ena     = 1'b1;
        wr_en   = 1'b0;
        wr_sel  = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        model_reset();

        // Held in reset with random writes: everything stays cleared.
        repeat (12) begin
            wr_en   = 1'b1;
            wr_sel  = 1'($urandom_range(0, 1));
            wr_addr = 2'($urandom_range(0, 3));
            wr_data = 12'($urandom_range(1, 15));
            step();
        end
        wr_en = 1'b0;
        rst_n = 1'b1;
        repeat (1000) step();
        check("idle_tone", 32'(tone_out), 32'd0);

        // Single tone, period 3: toggles every 4 edges after the write.
        wr(1'b0, 2'd0, 12'd3);
        for (int j = 1; j <= 12; j++) begin
            step();
            check("tone0_sched", 32'(tone_out[0]), 32'((j / 4) % 2));
            check("tone_others", 32'(tone_out[3:1]), 32'd0);
        end

        // Retune at the expiry edge, then mute.
        wr(1'b0, 2'd1, 12'd10);
        repeat (10) step();
        wr(1'b0, 2'd1, 12'd2);
        check("retune_no_toggle", 32'(tone_out[1]), 32'd0);
        repeat (2) step();
        check("retune_wait", 32'(tone_out[1]), 32'd0);
        step();
        check("retune_toggle", 32'(tone_out[1]), 32'd1);
        wr(1'b0, 2'd1, 12'd0);
        check("mute_write_hold", 32'(tone_out[1]), 32'd1);
        repeat (20) begin
            step();
            check("mute_zero", 32'(tone_out[1]), 32'd0);
        end

        // Enable freeze for 37 cycles shifts the schedule by 37.
        wr(1'b1, 2'd2, 12'd7);
        wr(1'b0, 2'd2, 12'd5);
        repeat (8) step();
        check("pre_freeze", 32'(tone_out[2]), 32'd1);
        ena = 1'b0;
        repeat (37) begin
            step();
            check("freeze_pwm", 32'(pwm_out), 32'd0);
            check("freeze_tone", 32'(tone_out[2]), 32'd1);
        end
        ena = 1'b1;
        repeat (3) step();
        check("resume_hold", 32'(tone_out[2]), 32'd1);
        step();
        check("resume_toggle", 32'(tone_out[2]), 32'd0);

        // Mixer duty: 5+9 of 128, then 4*15 of 128.
        async_reset();
        wr(1'b1, 2'd0, 12'd5);
        wr(1'b1, 2'd1, 12'd9);
        for (int i = 0; i < 4; i++) wr(1'b0, 2'(i), 12'd1000);
        repeat (1010) step();
        check("mix_all_high", 32'(tone_out), 32'hF);
        measure_frame(hi);
        check("duty_14", hi, 32'd14);
        for (int i = 0; i < 4; i++) wr(1'b1, 2'(i), 12'd15);
        measure_frame(hi);
        check("duty_60", hi, 32'd60);

        // Out-of-range address on the three-channel instance.
        async_reset();
        wr(1'b0, 2'd3, 12'd1);
        repeat (8) begin
            step();
            check("addr_oob", 32'(tone3), 32'd0);
        end
        wr(1'b0, 2'd2, 12'd1);
        step();
        check("addr_ok_wait", 32'(tone3), 32'd0);
        step();
        check("addr_ok_toggle", 32'(tone3), 32'h4);

        // Randomized traffic with one asynchronous reset mid-run.
        for (int c = 0; c < 2500; c++) begin
            ena     = ($urandom_range(0, 9) != 0);
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_sel  = 1'($urandom_range(0, 1));
            wr_addr = 2'($urandom_range(0, 3));
            wr_data = wr_sel ? 12'($urandom_range(0, 15)) : 12'($urandom_range(0, 20));
            step();
            if (c == 1200) begin
                wr_en = 1'b0;
                async_reset();
            end
        end
        wr_en = 1'b0;
        ena   = 1'b1;
        repeat (300) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
